eth_buffer_scheduler: RTL and testbench
=======================================

ETH_BUFFER_SCHEDULER -- requirements
Module: eth_buffer_scheduler

Interface
REQ-001 SHALL have parameter ETH_DATA_SIZE, default 1280, payload bytes per packet/bank.
REQ-002 SHALL have parameter HDR_OFFSET, default 50, first payload address (header bytes below it).
REQ-003 SHALL have parameter ADDR_W, default 11, RAM address width.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pix_valid  input  1  one-cycle strobe qualifying cam_data, synchronous to clk.
REQ-007 SHALL have port cam_data  input  8  camera pixel byte.
REQ-008 SHALL have port frame_done  input  1  one-cycle end-of-frame pulse.
REQ-009 SHALL have port eth_finish  input  1  one-cycle pulse: Ethernet controller finished current packet.
REQ-010 SHALL have port ram_wr_en  output  1  RAM write strobe.
REQ-011 SHALL have port ram_bank  output  1  bank select for the write.
REQ-012 SHALL have port ram_addr  output  ADDR_W  write address.
REQ-013 SHALL have port ram_din  output  8  write data.
REQ-014 SHALL have port eth_contr_reset  output  1  holds Ethernet controller in reset while high.
REQ-015 SHALL have port eth_start  output  1  one-cycle pulse when a send begins.
REQ-016 SHALL have port send_bank  output  1  bank the Ethernet controller reads.
REQ-017 SHALL have port send_rom  output  1  high: send marker packet from ROM, not RAM.
REQ-018 SHALL have port overflow  output  1  sticky: pixel dropped since reset.
REQ-019 SHALL have port drop_cnt  output  16  saturating count of dropped pixels.
REQ-020 SHALL have port FSM_state  output  2  current send-FSM state.

Function
REQ-021 Two banks; full[1:0] flags; write bank wb; read bank rb; write pointer wptr.
REQ-022 pix_valid with full[wb]=0: next cycle ram_wr_en=1, ram_bank=wb, ram_addr=wptr, ram_din=cam_data (1-cycle latency, registered); wptr increments.
REQ-023 Write at wptr=HDR_OFFSET+ETH_DATA_SIZE-1: full[wb] set, wb toggles, wptr returns to HDR_OFFSET.
REQ-024 pix_valid with full[wb]=1: no write; overflow set; drop_cnt increments, saturates at 16'hFFFF.
REQ-025 frame_done: wptr returns to HDR_OFFSET (partial line discarded), rom_pend set; a pix_valid in the same cycle is discarded, not counted.
REQ-026 Send FSM states: IDLE=0, SEND_DATA=1, SEND_ROM=2; value 3 unused, recovers to IDLE.
REQ-027 IDLE and full[rb]=1 -> SEND_DATA; send_bank=rb; eth_start pulses one cycle.
REQ-028 IDLE, full[rb]=0, rom_pend=1 -> SEND_ROM; send_rom=1; eth_start pulses; data banks take priority over marker.
REQ-029 SEND_DATA and eth_finish -> IDLE; full[rb] cleared; rb toggles.
REQ-030 SEND_ROM and eth_finish -> IDLE; rom_pend cleared; send_rom low.
REQ-031 eth_contr_reset=1 in IDLE, 0 in SEND_DATA/SEND_ROM; eth_finish in IDLE ignored.
REQ-032 Same-cycle set of full[wb] and clear of full[rb] SHALL both take effect; a new full bank is visible to IDLE the next cycle.
REQ-033 frame_done during SEND_ROM re-sets rom_pend only if it coincides with no eth_finish clear; simultaneous -> rom_pend stays 1.

Reset
REQ-034 reset: FSM IDLE, full=0, wb=rb=0, wptr=HDR_OFFSET, rom_pend=0, overflow=0, drop_cnt=0.
REQ-035 reset outputs: ram_wr_en=0, ram_bank=0, ram_addr=HDR_OFFSET, ram_din=0, eth_contr_reset=1, eth_start=0, send_bank=0, send_rom=0.
REQ-036 reset mid-send SHALL abandon packet; no eth_start until a bank refills.

Structure
REQ-037 Shared package holds FSM state constants, default HDR_OFFSET/ETH_DATA_SIZE.
REQ-038 One sub-module eth_buf_write_ptr (wptr, wb, full-set pulse, drop logic); FSM in top.

Verification (ETH_DATA_SIZE=4, HDR_OFFSET=50)
REQ-039 4 pix_valid bytes A0..A3 -> writes bank 0 addr 50..53, full[0]=1, eth_start, send_bank=0, eth_contr_reset=0.
REQ-040 12 bytes, no eth_finish -> banks 0,1 filled, last 4 dropped, overflow=1, drop_cnt=4.
REQ-041 2 bytes then frame_done -> no data send; SEND_ROM, send_rom=1; next byte written at addr 50.
REQ-042 Bank 0 full plus frame_done pending, eth_finish -> SEND_DATA bank 0 first, then SEND_ROM after next eth_finish.
REQ-043 reset asserted in SEND_DATA -> next cycle all REQ-035 values, FSM_state=0.

Source files
------------

// File: rtl/eth_buffer_scheduler_pkg.sv
// Shared constants for the two-bank Ethernet packet buffer scheduler:
// send-FSM state encoding and default packet geometry.
package eth_buffer_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_DATA = 2'd1,
        ST_SEND_ROM  = 2'd2
    } state_t;

    localparam int DEF_ETH_DATA_SIZE = 1280;
    localparam int DEF_HDR_OFFSET    = 50;
    localparam int DEF_ADDR_W        = 11;

endpackage

// File: rtl/eth_buf_write_ptr.sv
// Camera-side write path: registers pixel writes into the active bank,
// advances the write pointer and counts pixels dropped when that bank is full.
module eth_buf_write_ptr
    import eth_buffer_scheduler_pkg::*;
#(
    parameter int ETH_DATA_SIZE = DEF_ETH_DATA_SIZE,
    parameter int HDR_OFFSET    = DEF_HDR_OFFSET,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pix_valid,
    input  logic [7:0]        i_cam_data,
    input  logic              i_frame_done,
    input  logic [1:0]        i_full,
    output logic              o_ram_wr_en,
    output logic              o_ram_bank,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_din,
    output logic              o_wb,
    output logic              o_full_set,
    output logic              o_overflow,
    output logic [15:0]       o_drop_cnt
);

    localparam logic [ADDR_W-1:0] P_FIRST = ADDR_W'(HDR_OFFSET);
    localparam logic [ADDR_W-1:0] P_LAST  = ADDR_W'(HDR_OFFSET + ETH_DATA_SIZE - 1);

    logic              r_wb;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_wr_en;
    logic              r_bank;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din;
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;

    logic w_accept;
    logic w_drop;
    logic w_last;

    // A pixel coinciding with frame_done belongs to the discarded line.
    assign w_accept = i_pix_valid && !i_frame_done && !i_full[r_wb];
    assign w_drop   = i_pix_valid && !i_frame_done &&  i_full[r_wb];
    assign w_last   = (r_wptr == P_LAST);

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb       <= 1'b0;
            r_wptr     <= P_FIRST;
            r_wr_en    <= 1'b0;
            r_bank     <= 1'b0;
            r_addr     <= P_FIRST;
            r_din      <= 8'h00;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_bank <= r_wb;
                r_addr <= r_wptr;
                r_din  <= i_cam_data;
            end
            if (i_frame_done) begin
                r_wptr <= P_FIRST;
            end else if (w_accept) begin
                if (w_last) begin
                    r_wptr <= P_FIRST;
                    r_wb   <= ~r_wb;
                end else begin
                    r_wptr <= r_wptr + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_ram_wr_en = r_wr_en;
    assign o_ram_bank  = r_bank;
    assign o_ram_addr  = r_addr;
    assign o_ram_din   = r_din;
    assign o_wb        = r_wb;
    assign o_full_set  = w_accept && w_last;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: rtl/eth_buffer_scheduler.sv
// Two-bank ping-pong buffer between a camera and an Ethernet controller;
// the send FSM hands full banks (or an end-of-frame marker) to the controller.
module eth_buffer_scheduler
    import eth_buffer_scheduler_pkg::*;
#(
    parameter int ETH_DATA_SIZE = DEF_ETH_DATA_SIZE,
    parameter int HDR_OFFSET    = DEF_HDR_OFFSET,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [7:0]        cam_data,
    input  logic              frame_done,
    input  logic              eth_finish,
    output logic              ram_wr_en,
    output logic              ram_bank,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              eth_contr_reset,
    output logic              eth_start,
    output logic              send_bank,
    output logic              send_rom,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    output logic [1:0]        FSM_state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_full;
    logic [1:0] w_full_next;
    logic       r_rb;
    logic       r_rom_pend;
    logic       r_start;
    logic       w_wb;
    logic       w_full_set;
    logic       w_data_done;
    logic       w_rom_done;

    eth_buf_write_ptr #(
        .ETH_DATA_SIZE (ETH_DATA_SIZE),
        .HDR_OFFSET    (HDR_OFFSET),
        .ADDR_W        (ADDR_W)
    ) u_write_ptr (
        .clk          (clk),
        .reset        (reset),
        .i_pix_valid  (pix_valid),
        .i_cam_data   (cam_data),
        .i_frame_done (frame_done),
        .i_full       (r_full),
        .o_ram_wr_en  (ram_wr_en),
        .o_ram_bank   (ram_bank),
        .o_ram_addr   (ram_addr),
        .o_ram_din    (ram_din),
        .o_wb         (w_wb),
        .o_full_set   (w_full_set),
        .o_overflow   (overflow),
        .o_drop_cnt   (drop_cnt)
    );

    assign w_data_done = (r_state == ST_SEND_DATA) && eth_finish;
    assign w_rom_done  = (r_state == ST_SEND_ROM)  && eth_finish;

    // Set and clear target different banks, so both apply in the same cycle.
    always_comb begin
        w_full_next = r_full;
        if (w_full_set)  w_full_next[w_wb] = 1'b1;
        if (w_data_done) w_full_next[r_rb] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_start <= (r_state == ST_IDLE) && (w_next_state != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full     <= 2'b00;
            r_rb       <= 1'b0;
            r_rom_pend <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_data_done) r_rb <= ~r_rb;
            if (frame_done)      r_rom_pend <= 1'b1;
            else if (w_rom_done) r_rom_pend <= 1'b0;
        end
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rb])    w_next_state = ST_SEND_DATA;
                else if (r_rom_pend) w_next_state = ST_SEND_ROM;
                else                 w_next_state = ST_IDLE;
            end
            ST_SEND_DATA: w_next_state = eth_finish ? ST_IDLE : ST_SEND_DATA;
            ST_SEND_ROM:  w_next_state = eth_finish ? ST_IDLE : ST_SEND_ROM;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        eth_contr_reset = 1'b1;
        send_rom        = 1'b0;
        case (r_state)
            ST_SEND_DATA: eth_contr_reset = 1'b0;
            ST_SEND_ROM: begin
                eth_contr_reset = 1'b0;
                send_rom        = 1'b1;
            end
            default: ;
        endcase
    end

    assign eth_start = r_start;
    assign send_bank = r_rb;
    assign FSM_state = r_state;

endmodule

// File: tb/tb_eth_buffer_scheduler.sv
// Self-checking bench: writes and send starts are predicted into queues as
// stimulus is driven and compared when the DUT produces them.
module tb_eth_buffer_scheduler;

    localparam int DS = 4;
    localparam int HO = 50;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          frame_done = 1'b0;
    logic          eth_finish = 1'b0;
    logic          ram_wr_en, ram_bank, eth_contr_reset, eth_start;
    logic          send_bank, send_rom, overflow;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [15:0]   drop_cnt;
    logic [1:0]    FSM_state;

    eth_buffer_scheduler #(.ETH_DATA_SIZE(DS), .HDR_OFFSET(HO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .cam_data(cam_data),
        .frame_done(frame_done), .eth_finish(eth_finish),
        .ram_wr_en(ram_wr_en), .ram_bank(ram_bank), .ram_addr(ram_addr),
        .ram_din(ram_din), .eth_contr_reset(eth_contr_reset), .eth_start(eth_start),
        .send_bank(send_bank), .send_rom(send_rom), .overflow(overflow),
        .drop_cnt(drop_cnt), .FSM_state(FSM_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } wr_t;

    wr_t        wq[$];
    logic [4:0] sq[$];   // {send_rom, send_bank, eth_contr_reset, FSM_state}
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [1:0] m_full;
    logic       m_wb, m_rb;
    int         m_wptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_wr_en) begin
                if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else check("write", {ram_bank, ram_addr, ram_din}, wq.pop_front());
            end
            if (eth_start) begin
                if (sq.size() == 0) check("unexpected_start", 32'd1, 32'd0);
                else check("start", {send_rom, send_bank, eth_contr_reset, FSM_state}, sq.pop_front());
            end
        end
    end

    // One clock of stimulus; clr marks an eth_finish that ends a data send.
    task automatic drive(input logic pv, input logic [7:0] d, input logic fd,
                         input logic fin, input logic clr);
        wr_t e;
        pix_valid = pv; cam_data = d; frame_done = fd; eth_finish = fin;
        if (fd) begin
            m_wptr = HO;
        end else if (pv && !m_full[m_wb]) begin
            e.bank = m_wb; e.addr = AW'(m_wptr); e.din = d;
            wq.push_back(e);
            if (m_wptr == HO + DS - 1) begin
                m_full[m_wb] = 1'b1;
                m_wb = ~m_wb;
                m_wptr = HO;
            end else begin
                m_wptr++;
            end
        end
        if (clr) begin
            m_full[m_rb] = 1'b0;
            m_rb = ~m_rb;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0; frame_done = 1'b0; eth_finish = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic byte_in(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_send(input logic rom, input logic bank);
        sq.push_back({rom, bank, 1'b0, rom ? 2'd2 : 2'd1});
    endtask

    task automatic drain(input string tag);
        idle(4);
        check({tag, "_writes_pending"}, wq.size(), 0);
        check({tag, "_starts_pending"}, sq.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wq.delete(); sq.delete();
        m_full = 2'b00; m_wb = 1'b0; m_rb = 1'b0; m_wptr = HO;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"},       ram_wr_en, 0);
        check({tag, "_bank"},        ram_bank, 0);
        check({tag, "_addr"},        ram_addr, HO);
        check({tag, "_din"},         ram_din, 0);
        check({tag, "_contr_reset"}, eth_contr_reset, 1);
        check({tag, "_start"},       eth_start, 0);
        check({tag, "_send_bank"},   send_bank, 0);
        check({tag, "_send_rom"},    send_rom, 0);
        check({tag, "_overflow"},    overflow, 0);
        check({tag, "_drop_cnt"},    drop_cnt, 0);
        check({tag, "_state"},       FSM_state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_reset("por");

        // Single packet fills bank 0 and starts a data send.
        expect_send(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) byte_in(8'hA0 + 8'(i));
        idle(2);
        check("a_state", FSM_state, 1);
        check("a_contr_reset", eth_contr_reset, 0);
        check("a_send_bank", send_bank, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("a_idle", FSM_state, 0);
        check("a_contr_reset_back", eth_contr_reset, 1);
        drain("a");

        // Both banks full, four bytes dropped.
        do_reset();
        expect_send(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) byte_in(8'hB0 + 8'(i));
        idle(2);
        check("b_overflow", overflow, 1);
        check("b_drop_cnt", drop_cnt, 4);
        expect_send(1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("b_send_bank1", send_bank, 1);
        check("b_state", FSM_state, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("b_idle", FSM_state, 0);
        byte_in(8'h5A);
        drain("b");

        // Partial line then frame_done (with a coincident pixel) sends the marker.
        do_reset();
        byte_in(8'hC0);
        byte_in(8'hC1);
        expect_send(1'b1, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        byte_in(8'hC2);
        idle(1);
        check("c_state", FSM_state, 2);
        check("c_send_rom", send_rom, 1);
        check("c_drop_cnt", drop_cnt, 0);
        check("c_overflow", overflow, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("c_idle", FSM_state, 0);
        check("c_send_rom_low", send_rom, 0);
        drain("c");

        // Data banks win over a pending marker; frame_done with finish keeps it.
        do_reset();
        expect_send(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) byte_in(8'hD0 + 8'(i));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("d_bank0", send_bank, 0);
        expect_send(1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("d_bank1_state", FSM_state, 1);
        check("d_bank1", send_bank, 1);
        expect_send(1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("d_rom_state", FSM_state, 2);
        expect_send(1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("d_rom_again", FSM_state, 2);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("d_idle", FSM_state, 0);
        drain("d");

        // Bank 1 fills in the same cycle bank 0 is released.
        do_reset();
        expect_send(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) byte_in(8'hE0 + 8'(i));
        expect_send(1'b0, 1'b1);
        drive(1'b1, 8'hE7, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("e_bank1", send_bank, 1);
        check("e_state", FSM_state, 1);
        byte_in(8'hE8);
        drain("e");

        // Reset in the middle of a data send abandons it.
        do_reset();
        expect_send(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) byte_in(8'hF0 + 8'(i));
        idle(2);
        check("f_state", FSM_state, 1);
        do_reset();
        check_reset("f_rst");
        drain("f");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
